// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: arbitrates branch flushes, multi-cycle EX freezes,
// load-use stalls and halt requests, and keeps saturating performance counters.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset        asynchronous active-high reset
//   stall_req    load-use hazard flag (ID vs EX load)
//   branch_taken branch/jump resolved taken in EX this cycle
//   mdu_start    multi-cycle multiply/divide op in EX this cycle
//   halt_req     halt instruction present in ID
//   resume       single-cycle pulse releasing HALTED
//   clr_cnt      synchronous clear of both performance counters
//   pc_write, if_id_write, id_ex_write      write enables (1 = update)
//   if_id_flush, id_ex_flush, ex_mem_flush  bubble insertion
//   halted       high while in HALTED
//   stall_cnt    saturating count of stall/freeze cycles
//   flush_cnt    saturating count of branch flushes
module pipeline_hazard_controller #(
  parameter int unsigned MULT_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_req,
  input  logic        branch_taken,
  input  logic        mdu_start,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        clr_cnt,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WAIT_W = 4;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MULT_LATENCY - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic                stall_inc, flush_inc;

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state and Mealy outputs; reset forces defaults even if inputs are active
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    halted       = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    if (!reset) begin
      unique case (state_q)
        ST_RUN: begin
          if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
          end else if (mdu_start) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
            stall_inc    = 1'b1;
            wait_cnt_d   = WAIT_LOAD;
            state_d      = ST_WAIT;
          end else if (stall_req) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
          end else if (halt_req) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            state_d     = ST_HALTED;
          end
        end
        ST_WAIT: begin
          // Start cycle plus MULT_LATENCY-1 wait cycles gives the full freeze
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_flush = 1'b1;
          stall_inc    = 1'b1;
          if (wait_cnt_q == WAIT_W'(1)) begin
            state_d = ST_RUN;
          end else begin
            wait_cnt_d = wait_cnt_q - WAIT_W'(1);
          end
        end
        ST_HALTED: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_write = 1'b0;
          halted      = 1'b1;
          if (resume) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Saturating counters; clear wins over increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller (MULT_LATENCY=4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_pipeline_hazard_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_req, branch_taken, mdu_start, halt_req, resume, clr_cnt;
  logic        pc_write, if_id_write, id_ex_write;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic [6:0]  outs;

  int n_checks = 0;
  int n_fail   = 0;

  // {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_flush, halted}
  localparam logic [6:0] O_DEF    = 7'b1110000;
  localparam logic [6:0] O_BRANCH = 7'b1111100;
  localparam logic [6:0] O_FREEZE = 7'b0000010;
  localparam logic [6:0] O_STALL  = 7'b0010100;
  localparam logic [6:0] O_HALTED = 7'b0000001;

  pipeline_hazard_controller #(.MULT_LATENCY(4)) dut (
    .clk(clk), .reset(reset), .stall_req(stall_req), .branch_taken(branch_taken),
    .mdu_start(mdu_start), .halt_req(halt_req), .resume(resume), .clr_cnt(clr_cnt),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  assign outs = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_flush, halted};

  task automatic idle_inputs();
    stall_req = 0; branch_taken = 0; mdu_start = 0; halt_req = 0; resume = 0; clr_cnt = 0;
  endtask

  task automatic clear_counters();
    @(negedge clk); idle_inputs(); clr_cnt = 1;
    @(negedge clk); clr_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    #2;
    n_checks++; if (outs !== O_DEF) begin n_fail++; $display("FAIL reset_outs got %b exp %b", outs, O_DEF); end
    n_checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnts got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    @(negedge clk); @(negedge clk); reset = 0;
    #1;
    n_checks++; if (outs !== O_DEF) begin n_fail++; $display("FAIL post_reset_outs got %b exp %b", outs, O_DEF); end
  endtask

  task automatic test_stall();
    clear_counters();
    @(negedge clk); stall_req = 1; #1;
    n_checks++; if (outs !== O_STALL) begin n_fail++; $display("FAIL stall_outs got %b exp %b", outs, O_STALL); end
    @(negedge clk); stall_req = 0; #1;
    n_checks++; if (outs !== O_DEF) begin n_fail++; $display("FAIL stall_after got %b exp %b", outs, O_DEF); end
    n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL stall_cnt got %0d exp 1", stall_cnt); end
  endtask

  task automatic test_mdu();
    clear_counters();
    @(negedge clk); mdu_start = 1; #1;
    n_checks++; if (outs !== O_FREEZE) begin n_fail++; $display("FAIL mdu_start_outs got %b exp %b", outs, O_FREEZE); end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); mdu_start = 0; branch_taken = (i == 2); #1;
      n_checks++; if (outs !== O_FREEZE) begin
        n_fail++; $display("FAIL mdu_wait%0d_outs got %b exp %b", i, outs, O_FREEZE); end
    end
    @(negedge clk); branch_taken = 0; #1;
    n_checks++; if (outs !== O_DEF) begin n_fail++; $display("FAIL mdu_release got %b exp %b", outs, O_DEF); end
    n_checks++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL mdu_stall_cnt got %0d exp 4", stall_cnt); end
    n_checks++; if (flush_cnt !== 16'd0) begin n_fail++; $display("FAIL mdu_flush_cnt got %0d exp 0", flush_cnt); end
  endtask

  task automatic test_priority();
    clear_counters();
    @(negedge clk); branch_taken = 1; stall_req = 1; mdu_start = 1; halt_req = 1; #1;
    n_checks++; if (outs !== O_BRANCH) begin n_fail++; $display("FAIL prio_outs got %b exp %b", outs, O_BRANCH); end
    @(negedge clk); idle_inputs(); #1;
    n_checks++; if (outs !== O_DEF) begin n_fail++; $display("FAIL prio_after got %b exp %b", outs, O_DEF); end
    n_checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL prio_cnts got flush=%0d stall=%0d exp 1/0", flush_cnt, stall_cnt); end
  endtask

  task automatic test_halt();
    clear_counters();
    @(negedge clk); halt_req = 1; #1;
    n_checks++; if (outs !== O_STALL) begin n_fail++; $display("FAIL halt_req_outs got %b exp %b", outs, O_STALL); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); halt_req = 0; branch_taken = (i == 1); resume = (i == 4); #1;
      n_checks++; if (outs !== O_HALTED) begin
        n_fail++; $display("FAIL halted%0d_outs got %b exp %b", i, outs, O_HALTED); end
    end
    @(negedge clk); idle_inputs(); stall_req = 1; #1;
    n_checks++; if (outs !== O_STALL) begin n_fail++; $display("FAIL resume_run got %b exp %b", outs, O_STALL); end
    @(negedge clk); idle_inputs(); #1;
    n_checks++; if (outs !== O_DEF) begin n_fail++; $display("FAIL resume_after got %b exp %b", outs, O_DEF); end
    n_checks++; if (flush_cnt !== 16'd0 || stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL halt_cnts got flush=%0d stall=%0d exp 0/1", flush_cnt, stall_cnt); end
  endtask

  task automatic test_reset_in_wait();
    clear_counters();
    @(negedge clk); mdu_start = 1;
    @(negedge clk); mdu_start = 0;
    @(negedge clk); #1;
    n_checks++; if (outs !== O_FREEZE || stall_cnt !== 16'd2) begin
      n_fail++; $display("FAIL wait2 got %b cnt=%0d exp %b cnt=2", outs, stall_cnt, O_FREEZE); end
    #1 reset = 1; #1;
    n_checks++; if (outs !== O_DEF) begin n_fail++; $display("FAIL async_reset_outs got %b exp %b", outs, O_DEF); end
    n_checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_fail++; $display("FAIL async_reset_cnts got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    @(negedge clk); reset = 0; stall_req = 1; #1;
    n_checks++; if (outs !== O_STALL) begin n_fail++; $display("FAIL after_reset_run got %b exp %b", outs, O_STALL); end
    @(negedge clk); idle_inputs(); #1;
    n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL after_reset_cnt got %0d exp 1", stall_cnt); end
  endtask

  task automatic test_saturate();
    clear_counters();
    @(negedge clk); stall_req = 1;
    repeat (65534) @(negedge clk);
    #1;
    n_checks++; if (stall_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_fffe got %h exp fffe", stall_cnt); end
    @(negedge clk); #1;
    n_checks++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ffff got %h exp ffff", stall_cnt); end
    @(negedge clk); #1;
    n_checks++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h exp ffff", stall_cnt); end
    clr_cnt = 1;
    @(negedge clk); #1;
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_prio got %h exp 0000", stall_cnt); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_mdu();
    test_priority();
    test_halt();
    test_reset_in_wait();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The block SHALL have one parameter: MULT_LATENCY, default 4, total freeze cycles for a multi-cycle EX op; legal range 2..15.
REQ-002 The block SHALL have one clock, clk; reset is asynchronous and active-high, named reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 stall_req  input  1  load-use hazard flag from hazard detection (ID vs EX load).
REQ-006 branch_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-007 mdu_start  input  1  multi-cycle multiply/divide op in EX this cycle.
REQ-008 halt_req  input  1  halt instruction present in ID.
REQ-009 resume  input  1  single-cycle pulse releasing HALTED.
REQ-010 clr_cnt  input  1  synchronous clear of both performance counters.
REQ-011 pc_write, if_id_write, id_ex_write  output  1 each  register write enables; 1 = update.
REQ-012 if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  insert bubble into the named pipeline register.
REQ-013 halted  output  1  high while in HALTED.
REQ-014 stall_cnt  output  16  saturating count of stall/freeze cycles.
REQ-015 flush_cnt  output  16  saturating count of branch flushes.

Function
REQ-016 The FSM SHALL have states RUN, WAIT and HALTED, plus a 4-bit down-counter wait_cnt.
REQ-017 Default outputs SHALL be all write enables 1 and all flushes 0. Outputs are combinational from state and inputs (Mealy in RUN); state changes on the rising edge of clk.
REQ-018 RUN priority SHALL be branch_taken > mdu_start > stall_req > halt_req. Lower-priority requests in the same cycle are ignored.
REQ-019 RUN with branch_taken:
- if_id_flush=1, id_ex_flush=1, write enables 1.
- flush_cnt increments.
- Next state RUN.
REQ-020 RUN with mdu_start (no branch):
- pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_flush=1.
- wait_cnt loads MULT_LATENCY-1.
- stall_cnt increments.
- Next state WAIT.
REQ-021 WAIT:
- Same outputs as REQ-020; stall_cnt increments each cycle.
- If wait_cnt==1, next state RUN; else wait_cnt decrements.
- All inputs except reset are ignored.
- Total freeze is exactly MULT_LATENCY cycles, including the start cycle.
REQ-022 RUN with stall_req (no branch, no mdu_start):
- pc_write=0, if_id_write=0, id_ex_flush=1.
- stall_cnt increments.
- Next state RUN; one bubble per asserted cycle.
REQ-023 RUN with halt_req only:
- pc_write=0, if_id_write=0, id_ex_flush=1.
- Next state HALTED.
REQ-024 HALTED:
- All write enables 0, all flushes 0, halted=1.
- resume=1 moves to RUN next cycle. halted drops in that RUN cycle, and normal RUN rules (REQ-018 to REQ-023) apply from that cycle onward.
- Other inputs are ignored.
REQ-025 Counters SHALL saturate at 16'hFFFF. clr_cnt=1 forces both to 0 on the next edge and takes priority over increment.
REQ-026 Assertion of reset in any state SHALL immediately abort WAIT/HALTED and force reset values.

Reset
REQ-027 While reset=1, and asynchronously on its assertion:
- state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, halted=0.
- Outputs are at REQ-017 defaults (with inputs low).
REQ-028 The first rising edge after reset deasserts SHALL evaluate normal RUN rules.

Verification
REQ-029 stall_req=1 for 1 cycle, other inputs 0 -> that cycle pc_write=0, if_id_write=0, id_ex_flush=1; next cycle all defaults; stall_cnt=1.
REQ-030 mdu_start=1 for 1 cycle, MULT_LATENCY=4 -> exactly 4 consecutive cycles of pc_write=if_id_write=id_ex_write=0 with ex_mem_flush=1, then defaults; stall_cnt=4.
REQ-031 branch_taken=1 together with stall_req=1, mdu_start=1 and halt_req=1 -> if_id_flush=id_ex_flush=1, no freeze, state stays RUN; flush_cnt=1, stall_cnt=0.
REQ-032 halt_req=1 for 1 cycle, then resume pulse after 5 cycles -> halted=1 for 5 cycles with all writes 0; branch_taken in HALTED has no effect; RUN on the cycle after resume.
REQ-033 reset asserted during the 2nd WAIT cycle -> state RUN, outputs at defaults and counters 0 immediately (before the next edge).
REQ-034 Force stall_cnt to 16'hFFFF, then stall_req=1 -> stall_cnt stays 16'hFFFF. clr_cnt=1 with stall_req=1 -> stall_cnt=0 next cycle.
